round_sequencer: RTL

//  Central game FSM for the memory-pattern game. Once a level is chosen it

---
 rtl/round_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/round_sequencer.sv
// round_sequencer: game FSM driving generate/show/input rounds, judging wins and publishing the score
module round_sequencer #(
  parameter int NUM_ROUNDS     = 10,
  parameter int LRST_CYCLES    = 4,
  parameter int SETTLE_CYCLES  = 3,
  parameter int GAP_CYCLES     = 500,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        restart,
  input  logic        level_done,
  input  logic [2:0]  level,
  input  logic        pattern_gen_end,
  input  logic        print_end,
  input  logic        input_trim_end,
  input  logic        round_win,
  output logic        lrst_n,
  output logic        pg_enable,
  output logic [15:0] lv_mask,
  output logic [4:0]  round_count,
  output logic [3:0]  answer_count,
  output logic [6:0]  score,
  output logic        game_end,
  output logic        round_timeout,
  output logic [3:0]  state
);
  localparam logic [3:0] IDLE = 4'd0, RRST = 4'd1, GEN = 4'd2, SHOW = 4'd3, INPUT = 4'd4,
                         SETTLE = 4'd5, SCORE = 4'd6, GAP = 4'd7, DONE = 4'd8;
  localparam int CW = $clog2(TIMEOUT_CYCLES + GAP_CYCLES + LRST_CYCLES + SETTLE_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          win;
  logic [31:0]   lim;
  logic          hit;
  logic [3:0]    ans_next;
  logic          one_hot;
  // One shared counter; its terminal count depends on the state it is timing
  always_comb begin
    lim = state == RRST ? 32'(LRST_CYCLES) : state == INPUT ? 32'(TIMEOUT_CYCLES) :
          state == SETTLE ? 32'(SETTLE_CYCLES) : 32'(GAP_CYCLES);
    hit = 32'(cnt) + 32'd1 >= lim;
    ans_next = answer_count + {3'd0, win & (answer_count != 4'hf)};
    one_hot = level == 3'b001 || level == 3'b010 || level == 3'b100;
  end
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      lrst_n <= 1'b1;
      pg_enable <= 1'b0;
      lv_mask <= '0;
      round_count <= '0;
      answer_count <= '0;
      score <= '0;
      game_end <= 1'b0;
      round_timeout <= 1'b0;
      cnt <= '0;
      win <= 1'b0;
    end else if (restart) begin
      state <= IDLE;
      lrst_n <= 1'b1;
      pg_enable <= 1'b0;
      lv_mask <= '0;
      round_count <= '0;
      answer_count <= '0;
      score <= '0;
      game_end <= 1'b0;
      round_timeout <= 1'b0;
      cnt <= '0;
      win <= 1'b0;
    end else begin
      round_timeout <= 1'b0;
      case (state)
        IDLE: if (level_done && one_hot) begin
          lv_mask <= level[0] ? 16'h00ff : level[1] ? 16'h0fff : 16'hffff;
          state <= RRST;
          lrst_n <= 1'b0;
          cnt <= '0;
        end
        RRST: if (hit) begin
          state <= GEN;
          lrst_n <= 1'b1;
          pg_enable <= 1'b1;
        end else cnt <= cnt + 1'b1;
        GEN: if (pattern_gen_end) begin
          state <= SHOW;
          pg_enable <= 1'b0;
        end
        SHOW: if (print_end) begin
          state <= INPUT;
          cnt <= '0;
        end
        // A trim that lands on the timeout cycle still counts as a normal answer
        INPUT: if (input_trim_end) begin
          state <= SETTLE;
          cnt <= '0;
        end else if (hit) begin
          state <= SCORE;
          win <= 1'b0;
          round_timeout <= 1'b1;
        end else cnt <= cnt + 1'b1;
        SETTLE: if (hit) begin
          state <= SCORE;
          win <= round_win;
        end else cnt <= cnt + 1'b1;
        SCORE: begin
          round_count <= round_count + 1'b1;
          answer_count <= ans_next;
          if (32'(round_count) + 32'd1 == 32'(NUM_ROUNDS)) begin
            state <= DONE;
            game_end <= 1'b1;
            score <= 7'(ans_next) * 7'd10;
          end else begin
            state <= GAP;
            cnt <= '0;
          end
        end
        GAP: if (hit) begin
          state <= RRST;
          lrst_n <= 1'b0;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
